control_sequencer: RTL and testbench
====================================

# control_sequencer

Microprogrammed control sequencer for the 8-bit single-bus computer. It fetches, decodes and executes one instruction at a time by driving the OE/WE strobes of the PC, MAR, RAM, IR, A, B, ALU and OUT blocks on the shared bus. Every bus transfer takes two clocks, because register outputs update one clock after OE is asserted. The block holds no datapath. It only sequences it.

## Interface
- No parameters. Opcode map and step lengths are fixed.
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high
- start  in  1  level; sampled in IDLE to begin running
- opcode  in  4  IR stored high nibble; valid from the clock after ir_we
- zero  in  1  A==0 flag from ALU, sampled in DEC
- pc_oe, pc_we, pc_inc  out  1 each  program counter strobes
- mar_we  out  1  MAR load
- ram_oe, ram_we  out  1 each  RAM strobes
- ir_oe, ir_we  out  1 each  IR strobes (ir_oe drives low nibble to bus)
- a_oe, a_we, b_we  out  1 each  accumulator / B register strobes
- alu_oe, alu_sub  out  1 each  ALU drive, subtract select
- out_we  out  1  output register load
- tstate  out  3  current microstep: 1..5 = T1..T5, 0 = IDLE/DEC/HALT
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT

## Operation
- States: IDLE, T1, T2, DEC, T3, T4, T5, HALT.
- Each Tn has phase A and phase B, one clock each.
- Phase A asserts only the source OE.
- Phase B holds the same source OE and adds the destination WE. The destination captures the bus on the clock edge that ends phase B.
- All outputs are Moore-decoded from registered state (state, phase, op_q, z_q). There is no combinational input-to-output path.
- IDLE: if start=1, go to T1A on the next edge. Otherwise stay.
- Fetch:
  - T1: pc_oe, then mar_we.
  - T2: ram_oe, then ir_we. pc_inc is high in T2B only.
  - Then DEC.
- DEC: one clock with no strobes. Captures op_q←opcode and z_q←zero.
- Execute, by op_q:
  - LDA (0x0): T3 ir_oe→mar_we; T4 ram_oe→a_we.
  - ADD (0x1): T3 ir_oe→mar_we; T4 ram_oe→b_we; T5 alu_oe→a_we with alu_sub=0.
  - SUB (0x2): same as ADD, with alu_sub=1 held through all of T5.
  - STA (0x3): T3 ir_oe→mar_we; T4 a_oe→ram_we.
  - JMP (0x4): T3 ir_oe→pc_we.
  - JZ (0x5): if z_q=1, T3 ir_oe→pc_we. If z_q=0, T3 runs with no strobes.
  - OUT (0xE): T3 a_oe→out_we.
  - HLT (0xF): DEC goes directly to HALT.
  - All other opcodes are NOP: DEC goes directly to T1A.
- After the last used step's phase B, go to T1A. Unused steps are skipped.
- HALT: all strobes 0, halted=1. Stays in HALT until RESET. start is ignored.
- Never assert two OE signals at once.
- Never assert a WE outside phase B.

## Timing
- RESET asserted: immediately go to IDLE with phase A, op_q=0, z_q=0. All outputs are 0, including tstate, busy and halted.
- RESET mid-instruction aborts without completing any pending WE.
- Instruction length in clocks, counted from the T1A edge:
  - 9: LDA, STA
  - 11: ADD, SUB
  - 7: JMP, JZ, OUT
  - 5: NOP
  - 5, then HALT: HLT
- First T1A occurs 1 clock after start is sampled high in IDLE.
- start is not re-sampled while running.
- pc_inc and pc_we never coincide. JMP/JZ load the PC in T3B, after the T2B increment.

## Test plan
- Reset, then no start for 10 clocks -> all outputs 0, tstate=0, busy=0. Raise start -> next clock pc_oe=1, tstate=1. One clock later mar_we=1 is added.
- opcode=0x1 (ADD) -> 11-clock instruction. b_we high only in T4B. alu_oe+a_we+alu_sub=0 in T5B. Next clock is T1A.
- opcode=0x2 (SUB) -> alu_sub=1 in both T5A and T5B. Otherwise matches ADD.
- opcode=0x5 with zero=1 at DEC -> pc_we in T3B, 7 clocks total. Repeat with zero=0 -> no pc_we, still 7 clocks.
- opcode=0xF -> HALT after DEC, halted=1, busy=0. Toggle start for 20 clocks -> no change. RESET -> IDLE.
- Assert RESET asynchronously in T4A of STA -> outputs 0 immediately and ram_we never pulses. Release RESET, pulse start -> clean fetch begins.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute sequencer for the 8-bit
// single-bus computer. Drives bus strobes only; holds no datapath.
module control_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       zero,
  output logic       pc_oe,
  output logic       pc_we,
  output logic       pc_inc,
  output logic       mar_we,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       ir_oe,
  output logic       ir_we,
  output logic       a_oe,
  output logic       a_we,
  output logic       b_we,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_we,
  output logic [2:0] tstate,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_DEC,
    S_T3, S_T4, S_T5, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_oe;
    logic       pc_we;
    logic       pc_inc;
    logic       mar_we;
    logic       ram_oe;
    logic       ram_we;
    logic       ir_oe;
    logic       ir_we;
    logic       a_oe;
    logic       a_we;
    logic       b_we;
    logic       alu_oe;
    logic       alu_sub;
    logic       out_we;
    logic [2:0] tstate;
    logic       busy;
    logic       halted;
  } ctl_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     st_q, st_d;
  logic       ph_q, ph_d;
  logic [3:0] op_q, op_d;
  logic       z_q, z_d;
  ctl_t       ctl_q;

  function automatic logic has_exec(input logic [3:0] op);
    return (op <= OP_JZ) || (op == OP_OUT);
  endfunction

  // Step following phase B of a Tn; unused steps fall back to T1.
  function automatic state_t step_after(
    input state_t s, input logic [3:0] op);
    state_t n;
    n = S_T1;
    unique case (s)
      S_T1: n = S_T2;
      S_T2: n = S_DEC;
      S_T3: n = (op <= OP_STA) ? S_T4 : S_T1;
      S_T4: n = (op == 4'h1 || op == OP_SUB) ? S_T5 : S_T1;
      default: n = S_T1;
    endcase
    return n;
  endfunction

  // Phase A drives the source only; phase B (b=1) adds the destination.
  function automatic ctl_t decode(
    input state_t s, input logic b,
    input logic [3:0] op, input logic z);
    ctl_t c;
    c = '0;
    c.busy   = (s != S_IDLE) && (s != S_HALT);
    c.halted = (s == S_HALT);
    unique case (s)
      S_T1: begin
        c.tstate = 3'd1;
        c.pc_oe  = 1'b1;
        c.mar_we = b;
      end
      S_T2: begin
        c.tstate = 3'd2;
        c.ram_oe = 1'b1;
        c.ir_we  = b;
        c.pc_inc = b;
      end
      S_T3: begin
        c.tstate = 3'd3;
        unique case (1'b1)
          op <= OP_STA: begin
            c.ir_oe  = 1'b1;
            c.mar_we = b;
          end
          op == OP_JMP, (op == OP_JZ && z): begin
            c.ir_oe = 1'b1;
            c.pc_we = b;
          end
          op == OP_OUT: begin
            c.a_oe   = 1'b1;
            c.out_we = b;
          end
          default: ;
        endcase
      end
      S_T4: begin
        c.tstate = 3'd4;
        unique case (1'b1)
          op == OP_STA: begin
            c.a_oe   = 1'b1;
            c.ram_we = b;
          end
          op == OP_LDA: begin
            c.ram_oe = 1'b1;
            c.a_we   = b;
          end
          default: begin
            c.ram_oe = 1'b1;
            c.b_we   = b;
          end
        endcase
      end
      S_T5: begin
        c.tstate  = 3'd5;
        c.alu_oe  = 1'b1;
        c.a_we    = b;
        c.alu_sub = (op == OP_SUB);
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    st_d = st_q;
    ph_d = 1'b0;
    op_d = op_q;
    z_d  = z_q;
    unique case (st_q)
      S_IDLE: if (start) st_d = S_T1;
      S_DEC: begin
        op_d = opcode;
        z_d  = zero;
        if (opcode == OP_HLT)     st_d = S_HALT;
        else if (has_exec(opcode)) st_d = S_T3;
        else                       st_d = S_T1;
      end
      S_HALT: st_d = S_HALT;
      default: begin
        if (!ph_q) ph_d = 1'b1;
        else       st_d = step_after(st_q, op_q);
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st_q  <= S_IDLE;
      ph_q  <= 1'b0;
      op_q  <= 4'h0;
      z_q   <= 1'b0;
      ctl_q <= '0;
    end else begin
      st_q  <= st_d;
      ph_q  <= ph_d;
      op_q  <= op_d;
      z_q   <= z_d;
      ctl_q <= decode(st_d, ph_d, op_d, z_d);
    end
  end

  assign pc_oe   = ctl_q.pc_oe;
  assign pc_we   = ctl_q.pc_we;
  assign pc_inc  = ctl_q.pc_inc;
  assign mar_we  = ctl_q.mar_we;
  assign ram_oe  = ctl_q.ram_oe;
  assign ram_we  = ctl_q.ram_we;
  assign ir_oe   = ctl_q.ir_oe;
  assign ir_we   = ctl_q.ir_we;
  assign a_oe    = ctl_q.a_oe;
  assign a_we    = ctl_q.a_we;
  assign b_we    = ctl_q.b_we;
  assign alu_oe  = ctl_q.alu_oe;
  assign alu_sub = ctl_q.alu_sub;
  assign out_we  = ctl_q.out_we;
  assign tstate  = ctl_q.tstate;
  assign busy    = ctl_q.busy;
  assign halted  = ctl_q.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: transfer-table reference model plus directed
// and randomized stimulus for control_sequencer.
module tb_control_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic pc_oe, pc_we, pc_inc, mar_we, ram_oe, ram_we;
  logic ir_oe, ir_we, a_oe, a_we, b_we, alu_oe, alu_sub;
  logic out_we, busy, halted;
  logic [2:0] tstate;

  control_sequencer dut (
    .CLK(CLK), .RESET(RESET), .start(start),
    .opcode(opcode), .zero(zero),
    .pc_oe(pc_oe), .pc_we(pc_we), .pc_inc(pc_inc),
    .mar_we(mar_we), .ram_oe(ram_oe), .ram_we(ram_we),
    .ir_oe(ir_oe), .ir_we(ir_we), .a_oe(a_oe),
    .a_we(a_we), .b_we(b_we), .alu_oe(alu_oe),
    .alu_sub(alu_sub), .out_we(out_we), .tstate(tstate),
    .busy(busy), .halted(halted)
  );

  always #5 CLK = ~CLK;

  localparam logic [18:0] OUT_WE  = 19'h00001;
  localparam logic [18:0] ALU_SUB = 19'h00002;
  localparam logic [18:0] ALU_OE  = 19'h00004;
  localparam logic [18:0] B_WE    = 19'h00008;
  localparam logic [18:0] A_WE    = 19'h00010;
  localparam logic [18:0] A_OE    = 19'h00020;
  localparam logic [18:0] IR_WE   = 19'h00040;
  localparam logic [18:0] IR_OE   = 19'h00080;
  localparam logic [18:0] RAM_WE  = 19'h00100;
  localparam logic [18:0] RAM_OE  = 19'h00200;
  localparam logic [18:0] MAR_WE  = 19'h00400;
  localparam logic [18:0] PC_INC  = 19'h00800;
  localparam logic [18:0] PC_WE   = 19'h01000;
  localparam logic [18:0] PC_OE   = 19'h02000;
  localparam logic [18:0] BUSY    = 19'h20000;
  localparam logic [18:0] HALTED  = 19'h40000;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic [18:0] obs;
  assign obs = {halted, busy, tstate,
                pc_oe, pc_we, pc_inc, mar_we,
                ram_oe, ram_we, ir_oe, ir_we,
                a_oe, a_we, b_we, alu_oe,
                alu_sub, out_we};

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a queue of expected per-clock output words.
  logic [18:0] mq[$];
  int          mode = M_IDLE;

  function automatic void xfer(input logic [18:0] src,
                               input logic [18:0] dst,
                               input int t,
                               input logic [18:0] extra);
    logic [18:0] a;
    a = src | extra | BUSY | (19'(t) << 14);
    mq.push_back(a);
    mq.push_back(a | dst);
  endfunction

  function automatic void fetch();
    xfer(PC_OE, MAR_WE, 1, '0);
    xfer(RAM_OE, IR_WE | PC_INC, 2, '0);
    mq.push_back(BUSY);
  endfunction

  function automatic void exec(input logic [3:0] op,
                               input logic z);
    case (op)
      4'h0: begin
        xfer(IR_OE, MAR_WE, 3, '0);
        xfer(RAM_OE, A_WE, 4, '0);
      end
      4'h1, 4'h2: begin
        xfer(IR_OE, MAR_WE, 3, '0);
        xfer(RAM_OE, B_WE, 4, '0);
        xfer(ALU_OE, A_WE, 5,
             (op == 4'h2) ? ALU_SUB : '0);
      end
      4'h3: begin
        xfer(IR_OE, MAR_WE, 3, '0);
        xfer(A_OE, RAM_WE, 4, '0);
      end
      4'h4: xfer(IR_OE, PC_WE, 3, '0);
      4'h5: begin
        if (z) xfer(IR_OE, PC_WE, 3, '0);
        else   xfer('0, '0, 3, '0);
      end
      4'hE: xfer(A_OE, OUT_WE, 3, '0);
      default: ;
    endcase
  endfunction

  function automatic logic [18:0] exp_now();
    if (mode == M_RUN && mq.size() > 0) return mq[0];
    if (mode == M_HALT) return HALTED;
    return '0;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    logic [18:0] cur;
    if (RESET) begin
      mq.delete();
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE: if (start) begin
          fetch();
          mode = M_RUN;
        end
        M_RUN: begin
          cur = mq.pop_front();
          if (cur == BUSY) begin
            if (opcode == 4'hF) mode = M_HALT;
            else begin
              exec(opcode, zero);
              fetch();
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Compare process and per-instruction monitors.
  int cyc = 0, t1a_cyc = 0, t1a_seen = 0, last_len = 0;
  int cnt_bwe = 0, cnt_sub = 0, cnt_pcwe = 0;
  int last_bwe = 0, last_sub = 0, last_pcwe = 0;
  int ram_pulses = 0;

  always @(posedge ram_we) ram_pulses++;

  always @(negedge CLK) begin
    cyc++;
    if (pc_oe && !mar_we && tstate == 3'd1) begin
      last_len  = cyc - t1a_cyc;
      t1a_cyc   = cyc;
      t1a_seen++;
      last_bwe  = cnt_bwe;
      last_sub  = cnt_sub;
      last_pcwe = cnt_pcwe;
      cnt_bwe   = 0;
      cnt_sub   = 0;
      cnt_pcwe  = 0;
    end
    cnt_bwe  += int'(b_we);
    cnt_sub  += int'(alu_sub);
    cnt_pcwe += int'(pc_we);
    if (chk_on) chk("cycle", 32'(obs), 32'(exp_now()));
  end

  task automatic wait_t1a(input string nm);
    int s;
    bit ok;
    s  = t1a_seen;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      if (t1a_seen != s) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string nm,
                        input logic [3:0] op,
                        input logic z,
                        input int len);
    opcode = op;
    zero   = z;
    wait_t1a(nm);
    #1;
    chk({nm, "_len"}, last_len, len);
  endtask

  initial begin
    bit found;
    @(posedge CLK);
    chk_on = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("idle_out", 32'(obs), 0);

    @(posedge CLK);
    #1 start = 1'b1;
    opcode = 4'h1;
    @(posedge CLK);
    #1 start = 1'b0;
    @(negedge CLK);
    chk("t1a", {pc_oe, mar_we, tstate}, 5'b10001);
    @(negedge CLK);
    chk("t1b", {pc_oe, mar_we, tstate}, 5'b11001);

    run_op("add", 4'h1, 1'b0, 11);
    chk("add_bwe", last_bwe, 1);
    chk("add_sub", last_sub, 0);
    run_op("sub", 4'h2, 1'b0, 11);
    chk("sub_sub", last_sub, 2);
    chk("sub_bwe", last_bwe, 1);
    run_op("jz1", 4'h5, 1'b1, 7);
    chk("jz1_pcwe", last_pcwe, 1);
    run_op("jz0", 4'h5, 1'b0, 7);
    chk("jz0_pcwe", last_pcwe, 0);
    run_op("lda", 4'h0, 1'b0, 9);
    run_op("sta", 4'h3, 1'b1, 9);
    run_op("jmp", 4'h4, 1'b0, 7);
    chk("jmp_pcwe", last_pcwe, 1);
    run_op("out", 4'hE, 1'b1, 7);
    run_op("nop", 4'h7, 1'b0, 5);

    for (int i = 0; i < 1500; i++) begin
      @(posedge CLK);
      #1;
      opcode = 4'($urandom_range(0, 14));
      zero   = 1'($urandom);
      start  = 1'($urandom);
    end

    opcode = 4'hF;
    found  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (halted) begin
        found = 1'b1;
        break;
      end
    end
    chk("hlt_reached", found, 1);
    chk("hlt_busy", busy, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1 start = ~start;
    end
    @(negedge CLK);
    chk("hlt_stay", {halted, busy, tstate}, 5'b10000);

    @(posedge CLK);
    #1 RESET = 1'b1;
    start = 1'b0;
    #1 chk("hlt_reset", 32'(obs), 0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (3) @(posedge CLK);

    #1 opcode = 4'h3;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    ram_pulses = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (tstate == 3'd4 && a_oe && !ram_we) begin
        found = 1'b1;
        break;
      end
    end
    chk("sta_t4a", found, 1);
    #1 RESET = 1'b1;
    #1 chk("sta_abort", 32'(obs), 0);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("sta_no_ramwe", ram_pulses, 0);

    @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    @(negedge CLK);
    chk("restart_t1a", {pc_oe, mar_we, tstate}, 5'b10001);
    repeat (20) @(posedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
